silife_grid_arbiter: RTL and testbench
======================================

Name: silife_grid_arbiter

Overview:
Owns the single row-write port of the SiLife cell grid and shares it between three writers: the demo-pattern loader, the host (SPI) loader, and an internal clear sweep. It also schedules generation steps so the grid only evolves while no writer holds the port. It sits between the loaders and the grid array, and all grid writes pass through it.

Parameters:
ROWS, 32, number of grid rows (power of two)
ROW_BITS, 5, width of row index, equal to log2(ROWS)
COLS, 8, cells per row (width of one row write)
GRANT_MAX, 64, maximum grant hold in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clear_req  in  1  pulse: request a full-grid clear
demo_req  in  1  demo loader requests the port (level)
demo_row_select  in  ROW_BITS  demo row index
demo_cells  in  COLS  demo row data
demo_wr_en  in  1  demo write strobe
demo_gnt  out  1  demo loader owns the port
host_req  in  1  host loader requests the port (level)
host_row_select  in  ROW_BITS  host row index
host_cells  in  COLS  host row data
host_wr_en  in  1  host write strobe
host_gnt  out  1  host loader owns the port
run_en  in  1  evolution enabled
step_tick  in  1  pulse: generation period elapsed
grid_row_select  out  ROW_BITS  row index to grid
grid_cells  out  COLS  row data to grid
grid_wr_en  out  1  row write strobe to grid
grid_step  out  1  one-cycle pulse: advance one generation
busy  out  1  port owned (state != IDLE) or clear pending

Behaviour:
- Reset: clk and rst_n (synchronous, active-low) are the only clock and reset. On reset: state=IDLE; all outputs 0; clear_pend=0; step_pend=0.
- States: IDLE, CLEAR, DEMO, HOST.
- clear_pend is set by clear_req in any state except CLEAR, where clear_req is ignored. It is cleared on entry to CLEAR.
- Priority, evaluated only in IDLE: clear_pend > host_req > demo_req. The chosen state is entered on the next edge. A grant is never pre-empted by a higher-priority request.
- DEMO/HOST:
  - gnt=1 while in the state.
  - Each cycle the grid outputs register the owner's row_select and cells, and grid_wr_en registers the owner's wr_en. Latency is 1 cycle from input to grid_*.
  - A non-owner's wr_en is ignored. No write is ever lost or duplicated for the owner.
  - When the owner's req is sampled low, return to IDLE; gnt drops on that edge.
  - At least one IDLE cycle separates any two grants.
- CLEAR:
  - Internal counter sweeps rows 0..ROWS-1, one row per cycle, with grid_cells=0 and grid_wr_en=1. Total ROWS write cycles.
  - After row ROWS-1 the block returns to IDLE and grid_wr_en=0 on the following cycle.
  - The counter does not wrap past ROWS-1.
- Outside DEMO/HOST/CLEAR, grid_wr_en=0. grid_row_select and grid_cells hold their last values.
- Step scheduling:
  - step_tick sets step_pend. Multiple ticks before service collapse into one.
  - grid_step pulses for 1 cycle when state=IDLE, run_en=1, step_pend=1, and no clear_pend, host_req or demo_req is present that cycle. step_pend clears on the same edge.
  - When run_en=0, step_pend is cleared and ticks are discarded.
  - grid_step and grid_wr_en are never high in the same cycle.
- Simultaneous events: clear_req arriving in the same cycle as host_req in IDLE is not yet pending, so HOST wins. The clear is served after HOST releases.
- Reset mid-operation: an in-progress grant or clear is aborted immediately and no pending requests survive.

Optional Feature:
Macro SILIFE_ARB_WATCHDOG_EN.
- Defined: a hold counter runs in DEMO/HOST. If the grant lasts GRANT_MAX cycles, the block returns to IDLE and gnt drops. That requester is locked out until its req is sampled low once; other requesters may be granted meanwhile.
- Undefined: grants are held indefinitely while req stays high, the counter is absent, and GRANT_MAX is unused.

Test Plan:
- Reset then idle: grid_wr_en=0, gnt=0, busy=0. After clear_req, exactly 32 consecutive writes to rows 0..31 with cells=0x00, then busy=0.
- demo_req held with 32 row writes of pattern 0xA5 -> grid shows the same 32 writes 1 cycle later. On demo_req low, demo_gnt falls, and host_gnt is not asserted for at least 1 cycle.
- host_req and demo_req rise together -> host_gnt=1 and demo_gnt=0. Demo is granted only after host releases plus one IDLE cycle. Demo writes made during the host grant never reach the grid.
- clear_req during a demo grant -> demo is not pre-empted. The clear sweep starts from IDLE after release. A second clear_req during the sweep is not re-queued.
- run_en=1 with 3 step_ticks while host holds the port -> exactly one grid_step after release, and none while any req is high. With run_en=0 and a tick -> no grid_step.
- With SILIFE_ARB_WATCHDOG_EN, GRANT_MAX=64, and demo_req held 100 cycles -> demo_gnt drops after 64 cycles and is not re-granted until demo_req toggles low. A host_req raised meanwhile is granted.

Source files
------------

// File: rtl/silife_grid_arbiter.sv
// SiLife grid row-write port arbiter: clear sweep, host and demo loaders, step scheduling.
// Optional grant watchdog: define SILIFE_ARB_WATCHDOG_EN.
module silife_grid_arbiter #(
  parameter int ROWS      = 32,
  parameter int ROW_BITS  = 5,
  parameter int COLS      = 8,
  parameter int GRANT_MAX = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_req,
  input  logic                demo_req,
  input  logic [ROW_BITS-1:0] demo_row_select,
  input  logic [COLS-1:0]     demo_cells,
  input  logic                demo_wr_en,
  output logic                demo_gnt,
  input  logic                host_req,
  input  logic [ROW_BITS-1:0] host_row_select,
  input  logic [COLS-1:0]     host_cells,
  input  logic                host_wr_en,
  output logic                host_gnt,
  input  logic                run_en,
  input  logic                step_tick,
  output logic [ROW_BITS-1:0] grid_row_select,
  output logic [COLS-1:0]     grid_cells,
  output logic                grid_wr_en,
  output logic                grid_step,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DEMO,
    HOST
  } state_t;

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  state_t              state;
  logic                clear_pend;
  logic                step_pend;
  logic [ROW_BITS-1:0] clr_cnt;
  logic                demo_ok;
  logic                host_ok;
  logic                step_go;

`ifdef SILIFE_ARB_WATCHDOG_EN
  localparam int HW = $clog2(GRANT_MAX + 1);

  logic [HW-1:0] hold_cnt;
  logic          hold_end;
  logic          demo_lock;
  logic          host_lock;

  assign hold_end = (hold_cnt == HW'(GRANT_MAX - 1));
  assign demo_ok  = demo_req && !demo_lock;
  assign host_ok  = host_req && !host_lock;
`else
  assign demo_ok  = demo_req;
  assign host_ok  = host_req;
`endif

  // Raw requests (even locked ones) hold off evolution.
  assign step_go = (state == IDLE) && run_en && step_pend &&
                   !clear_pend && !host_req && !demo_req;

  assign busy = (state != IDLE) || clear_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      clear_pend      <= 1'b0;
      step_pend       <= 1'b0;
      clr_cnt         <= '0;
      demo_gnt        <= 1'b0;
      host_gnt        <= 1'b0;
      grid_row_select <= '0;
      grid_cells      <= '0;
      grid_wr_en      <= 1'b0;
      grid_step       <= 1'b0;
`ifdef SILIFE_ARB_WATCHDOG_EN
      hold_cnt        <= '0;
      demo_lock       <= 1'b0;
      host_lock       <= 1'b0;
`endif
    end else begin
      grid_step <= step_go;

      if (!run_en)        step_pend <= 1'b0;
      else if (step_go)   step_pend <= 1'b0;
      else if (step_tick) step_pend <= 1'b1;

      if (state == IDLE && clear_pend)
        clear_pend <= 1'b0;
      else if (clear_req && state != CLEAR)
        clear_pend <= 1'b1;

`ifdef SILIFE_ARB_WATCHDOG_EN
      if (!demo_req) demo_lock <= 1'b0;
      if (!host_req) host_lock <= 1'b0;
`endif

      unique case (state)
        IDLE: begin
          grid_wr_en <= 1'b0;
          if (clear_pend) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (host_ok) begin
            state    <= HOST;
            host_gnt <= 1'b1;
`ifdef SILIFE_ARB_WATCHDOG_EN
            hold_cnt <= '0;
`endif
          end else if (demo_ok) begin
            state    <= DEMO;
            demo_gnt <= 1'b1;
`ifdef SILIFE_ARB_WATCHDOG_EN
            hold_cnt <= '0;
`endif
          end
        end
        CLEAR: begin
          grid_row_select <= clr_cnt;
          grid_cells      <= '0;
          grid_wr_en      <= 1'b1;
          if (clr_cnt == LAST_ROW)
            state <= IDLE;
          else
            clr_cnt <= clr_cnt + ROW_BITS'(1);
        end
        DEMO: begin
          grid_row_select <= demo_row_select;
          grid_cells      <= demo_cells;
          grid_wr_en      <= demo_wr_en;
          if (!demo_req) begin
            state    <= IDLE;
            demo_gnt <= 1'b0;
`ifdef SILIFE_ARB_WATCHDOG_EN
          end else if (hold_end) begin
            state     <= IDLE;
            demo_gnt  <= 1'b0;
            demo_lock <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
`endif
          end
        end
        HOST: begin
          grid_row_select <= host_row_select;
          grid_cells      <= host_cells;
          grid_wr_en      <= host_wr_en;
          if (!host_req) begin
            state    <= IDLE;
            host_gnt <= 1'b0;
`ifdef SILIFE_ARB_WATCHDOG_EN
          end else if (hold_end) begin
            state     <= IDLE;
            host_gnt  <= 1'b0;
            host_lock <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_silife_grid_arbiter.sv
// Self-checking bench for silife_grid_arbiter.
// Table-driven arbitration vectors plus directed multi-cycle sequences.
module tb_silife_grid_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_req;
  logic       demo_req;
  logic [4:0] demo_row_select;
  logic [7:0] demo_cells;
  logic       demo_wr_en;
  logic       demo_gnt;
  logic       host_req;
  logic [4:0] host_row_select;
  logic [7:0] host_cells;
  logic       host_wr_en;
  logic       host_gnt;
  logic       run_en;
  logic       step_tick;
  logic [4:0] grid_row_select;
  logic [7:0] grid_cells;
  logic       grid_wr_en;
  logic       grid_step;
  logic       busy;

  int checks = 0;
  int errors = 0;

  silife_grid_arbiter #(
    .ROWS(32),
    .ROW_BITS(5),
    .COLS(8),
    .GRANT_MAX(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear_req(clear_req),
    .demo_req(demo_req),
    .demo_row_select(demo_row_select),
    .demo_cells(demo_cells),
    .demo_wr_en(demo_wr_en),
    .demo_gnt(demo_gnt),
    .host_req(host_req),
    .host_row_select(host_row_select),
    .host_cells(host_cells),
    .host_wr_en(host_wr_en),
    .host_gnt(host_gnt),
    .run_en(run_en),
    .step_tick(step_tick),
    .grid_row_select(grid_row_select),
    .grid_cells(grid_cells),
    .grid_wr_en(grid_wr_en),
    .grid_step(grid_step),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       dr;
    logic [4:0] drow;
    logic [7:0] dcel;
    logic       dwr;
    logic       hr;
    logic [4:0] hrow;
    logic [7:0] hcel;
    logic       hwr;
    logic       dg;
    logic       hg;
    logic       wr;
    logic [4:0] row;
    logic [7:0] cel;
    logic       bsy;
  } vec_t;

  function automatic vec_t mk(
    input logic       clr,
    input logic       dr,
    input logic [4:0] drow,
    input logic [7:0] dcel,
    input logic       dwr,
    input logic       hr,
    input logic [4:0] hrow,
    input logic [7:0] hcel,
    input logic       hwr,
    input logic       dg,
    input logic       hg,
    input logic       wr,
    input logic [4:0] row,
    input logic [7:0] cel,
    input logic       bsy
  );
    vec_t v;
    v.clr = clr; v.dr = dr; v.drow = drow; v.dcel = dcel; v.dwr = dwr;
    v.hr = hr; v.hrow = hrow; v.hcel = hcel; v.hwr = hwr;
    v.dg = dg; v.hg = hg; v.wr = wr; v.row = row; v.cel = cel; v.bsy = bsy;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  vec_t tbl[11];
  int   n;
  int   exp_n;
  logic exp_h;

  initial begin
    tbl[0]  = mk(0, 1, 0,  8'h00, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0,  8'h00, 1);
    tbl[1]  = mk(0, 1, 7,  8'hFF, 1, 1, 3, 8'h3C, 1, 0, 1, 1, 3,  8'h3C, 1);
    tbl[2]  = mk(0, 1, 8,  8'hFF, 1, 1, 4, 8'h11, 0, 0, 1, 0, 4,  8'h11, 1);
    tbl[3]  = mk(0, 1, 0,  8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0,  8'h00, 0);
    tbl[4]  = mk(0, 1, 0,  8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0,  8'h00, 1);
    tbl[5]  = mk(0, 1, 9,  8'h5A, 1, 0, 0, 8'h00, 0, 1, 0, 1, 9,  8'h5A, 1);
    tbl[6]  = mk(1, 1, 9,  8'h5A, 0, 0, 0, 8'h00, 0, 1, 0, 0, 9,  8'h5A, 1);
    tbl[7]  = mk(0, 1, 10, 8'h0F, 1, 0, 0, 8'h00, 0, 1, 0, 1, 10, 8'h0F, 1);
    tbl[8]  = mk(0, 0, 10, 8'h0F, 0, 0, 0, 8'h00, 0, 0, 0, 0, 10, 8'h0F, 1);
    tbl[9]  = mk(0, 0, 0,  8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 10, 8'h0F, 1);
    tbl[10] = mk(0, 0, 0,  8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0,  8'h00, 1);

    rst_n = 1'b0;
    clear_req = 0; demo_req = 0; demo_row_select = 0; demo_cells = 0;
    demo_wr_en = 0; host_req = 0; host_row_select = 0; host_cells = 0;
    host_wr_en = 0; run_en = 0; step_tick = 0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_wr", grid_wr_en, 0);
    chk("rst_dg", demo_gnt, 0);
    chk("rst_hg", host_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", grid_step, 0);
    chk("rst_row", grid_row_select, 0);
    chk("rst_cel", grid_cells, 0);

    // full clear sweep; a second clear during the sweep is ignored
    clear_req = 1;
    tick();
    clear_req = 0;
    chk("clr_pend_busy", busy, 1);
    chk("clr_pend_wr", grid_wr_en, 0);
    tick();
    chk("clr_start_wr", grid_wr_en, 0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("clr_wr", grid_wr_en, 1);
      chk("clr_row", grid_row_select, i);
      chk("clr_cel", grid_cells, 0);
      chk("clr_busy", busy, (i < 31) ? 1 : 0);
      clear_req = (i == 5);
    end
    clear_req = 0;
    n = 0;
    repeat (5) begin
      tick();
      n += grid_wr_en;
      n += busy;
    end
    chk("clr_done", n, 0);

    // demo loader writes 32 rows of 0xA5
    demo_req = 1;
    tick();
    chk("demo_gnt", demo_gnt, 1);
    chk("demo_hg", host_gnt, 0);
    chk("demo_wr0", grid_wr_en, 0);
    for (int r = 0; r < 32; r++) begin
      demo_row_select = r[4:0];
      demo_cells = 8'hA5;
      demo_wr_en = 1;
      tick();
      chk("demo_wr", grid_wr_en, 1);
      chk("demo_row", grid_row_select, r);
      chk("demo_cel", grid_cells, 8'hA5);
    end
    demo_wr_en = 0;
    demo_req = 0;
    host_req = 1;
    tick();
    chk("demo_rel_dg", demo_gnt, 0);
    chk("demo_rel_hg", host_gnt, 0);
    chk("demo_rel_wr", grid_wr_en, 0);
    tick();
    chk("host_after_gap", host_gnt, 1);
    host_req = 0;
    tick();
    chk("host_rel", host_gnt, 0);

    // arbitration table: host beats demo, clear waits for demo release
    for (int k = 0; k < 11; k++) begin
      clear_req = tbl[k].clr;
      demo_req = tbl[k].dr;
      demo_row_select = tbl[k].drow;
      demo_cells = tbl[k].dcel;
      demo_wr_en = tbl[k].dwr;
      host_req = tbl[k].hr;
      host_row_select = tbl[k].hrow;
      host_cells = tbl[k].hcel;
      host_wr_en = tbl[k].hwr;
      tick();
      chk($sformatf("t%0d_dg", k), demo_gnt, tbl[k].dg);
      chk($sformatf("t%0d_hg", k), host_gnt, tbl[k].hg);
      chk($sformatf("t%0d_wr", k), grid_wr_en, tbl[k].wr);
      chk($sformatf("t%0d_row", k), grid_row_select, tbl[k].row);
      chk($sformatf("t%0d_cel", k), grid_cells, tbl[k].cel);
      chk($sformatf("t%0d_busy", k), busy, tbl[k].bsy);
      chk($sformatf("t%0d_step", k), grid_step, 0);
    end
    clear_req = 0;
    for (int i = 1; i < 32; i++) begin
      tick();
      chk("tail_wr", grid_wr_en, 1);
      chk("tail_row", grid_row_select, i);
    end
    chk("tail_busy", busy, 0);
    tick();
    chk("tail_wr_off", grid_wr_en, 0);

    // step scheduling while host holds the port
    run_en = 1;
    host_req = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      step_tick = 1;
      tick();
      chk("step_hold_a", grid_step, 0);
      step_tick = 0;
      tick();
      chk("step_hold_b", grid_step, 0);
    end
    host_req = 0;
    tick();
    chk("step_rel", grid_step, 0);
    tick();
    chk("step_pulse", grid_step, 1);
    chk("step_nowr", grid_wr_en, 0);
    n = 0;
    repeat (10) begin
      tick();
      n += grid_step;
    end
    chk("step_once", n, 0);
    step_tick = 1;
    tick();
    step_tick = 0;
    chk("step_idle_a", grid_step, 0);
    tick();
    chk("step_idle_b", grid_step, 1);
    run_en = 0;
    step_tick = 1;
    tick();
    step_tick = 0;
    run_en = 1;
    n = 0;
    repeat (6) begin
      tick();
      n += grid_step;
    end
    chk("step_discard", n, 0);
    run_en = 0;

    // long demo hold
`ifdef SILIFE_ARB_WATCHDOG_EN
    exp_n = 64;
    exp_h = 1'b1;
`else
    exp_n = 100;
    exp_h = 1'b0;
`endif
    demo_req = 1;
    n = 0;
    repeat (100) begin
      tick();
      n += demo_gnt;
    end
    chk("hold_len", n, exp_n);
    host_req = 1;
    tick();
    chk("hold_host", host_gnt, exp_h);
    demo_req = 0;
    host_req = 0;
    tick();
    tick();
    demo_req = 1;
    tick();
    chk("hold_regrant", demo_gnt, 1);
    demo_req = 0;
    tick();
    tick();

    // reset mid-grant drops grant and pending clear
    demo_req = 1;
    tick();
    clear_req = 1;
    tick();
    clear_req = 0;
    chk("mid_busy", busy, 1);
    rst_n = 0;
    demo_req = 0;
    tick();
    chk("mid_rst_dg", demo_gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr", grid_wr_en, 0);
    rst_n = 1;
    n = 0;
    repeat (4) begin
      tick();
      n += busy;
      n += grid_wr_en;
    end
    chk("mid_no_pend", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
